fifo_dev: RTL and testbench

FIFO_DEV -- requirements
Module: fifo_dev

---
 rtl/fifo_dev.sv | 127 ++++++++++++
 tb/tb_fifo_dev.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_dev.sv
// rtl/fifo_dev.sv - bus-side byte FIFO bridge: RX (host->bus) and TX (bus->host) circular buffers
// Bus strobes are active-low and edge-detected against their one-clock delayed copies.
module fifo_dev #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_rd,
    input  logic       fifo_wr,
    output logic       fifo_rxf,
    output logic       fifo_txe,
    inout  wire  [6:0] fifo_data,
    input  logic [6:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [6:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       err_rd_empty,
    output logic       err_wr_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [6:0]  r_rx_mem [DEPTH];
    logic [6:0]  r_tx_mem [DEPTH];
    logic [AW:0] r_rx_wp;
    logic [AW:0] r_rx_rp;
    logic [AW:0] r_tx_wp;
    logic [AW:0] r_tx_rp;
    logic        r_rd_q;
    logic        r_wr_q;
    logic        r_drive_en;
    logic [6:0]  r_dout;
    logic [6:0]  r_cap;
    logic        r_rxf;
    logic        r_txe;
    logic        r_err_rd;
    logic        r_err_wr;

    logic        w_rd_fall;
    logic        w_rd_rise;
    logic        w_wr_rise;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_tx_push;
    logic        w_tx_pop;

    assign w_rd_fall  = r_rd_q & ~fifo_rd;
    assign w_rd_rise  = ~r_rd_q & fifo_rd;
    assign w_wr_rise  = ~r_wr_q & fifo_wr;

    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);

    // A bus pop in the same cycle frees the slot, so a full RX may still accept a host byte.
    assign w_rx_pop   = w_rd_rise & r_drive_en;
    assign rx_ready   = ~w_rx_full | w_rx_pop;
    assign w_rx_push  = rx_valid & rx_ready;

    assign tx_valid   = ~w_tx_empty;
    assign tx_data    = r_tx_mem[r_tx_rp[AW-1:0]];
    assign w_tx_pop   = tx_valid & tx_ready;
    assign w_tx_push  = w_wr_rise & (~w_tx_full | w_tx_pop);

    assign fifo_data    = r_drive_en ? r_dout : 7'bzzzzzzz;
    assign fifo_rxf     = r_rxf;
    assign fifo_txe     = r_txe;
    assign err_rd_empty = r_err_rd;
    assign err_wr_full  = r_err_wr;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wp[AW-1:0]] <= rx_data;
        end
        if (w_tx_push) begin
            r_tx_mem[r_tx_wp[AW-1:0]] <= r_cap;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_rd_q     <= 1'b1;
            r_wr_q     <= 1'b1;
            r_drive_en <= 1'b0;
            r_dout     <= '0;
            r_cap      <= '0;
            r_rxf      <= 1'b1;
            r_txe      <= 1'b1;
            r_err_rd   <= 1'b0;
            r_err_wr   <= 1'b0;
        end else begin
            r_rd_q <= fifo_rd;
            r_wr_q <= fifo_wr;

            if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_ONE;
            if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_ONE;

            if (w_rd_fall && !w_rx_empty) begin
                r_dout     <= r_rx_mem[r_rx_rp[AW-1:0]];
                r_drive_en <= 1'b1;
            end else if (w_rx_pop) begin
                r_drive_en <= 1'b0;
            end
            if (w_rd_fall && w_rx_empty) r_err_rd <= 1'b1;

            // Held high from the edge that sees the strobe low until the edge after it returns high.
            r_rxf <= ~(fifo_rd & r_rd_q) | w_rx_empty;

            if (!fifo_wr) r_cap <= fifo_data;
            if (w_wr_rise && !w_tx_push) r_err_wr <= 1'b1;
            r_txe <= ~fifo_wr | w_tx_full;
        end
    end
endmodule

// File: tb/tb_fifo_dev.sv
// tb/tb_fifo_dev.sv - directed vector bench for fifo_dev
module tb_fifo_dev;
    localparam int DEPTH = 8;
    localparam logic [6:0] BUS_Z = 7'h7f;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       fifo_rd = 1'b1;
    logic       fifo_wr = 1'b1;
    logic       fifo_rxf;
    logic       fifo_txe;
    wire  [6:0] fifo_data;
    logic [6:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [6:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       err_rd_empty;
    logic       err_wr_full;

    logic       tb_drv = 1'b0;
    logic [6:0] tb_val = '0;

    int n_cmp = 0;
    int n_fail = 0;

    assign fifo_data = tb_drv ? tb_val : 7'bzzzzzzz;
    for (genvar g = 0; g < 7; g++) begin : g_pu
        pullup (fifo_data[g]);
    end

    always #5 clk = ~clk;

    fifo_dev #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .fifo_rd(fifo_rd), .fifo_wr(fifo_wr),
        .fifo_rxf(fifo_rxf), .fifo_txe(fifo_txe), .fifo_data(fifo_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err_rd_empty(err_rd_empty), .err_wr_full(err_wr_full)
    );

    typedef struct {
        logic       rd, wr, drv;
        logic [6:0] dval, rxd;
        logic       rxv, txr;
        logic       e_rxf, e_txe, e_rxr, e_txv;
        logic [6:0] e_txd, e_bus;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rd, input logic wr, input logic drv, input logic [6:0] dval,
                       input logic [6:0] rxd, input logic rxv, input logic txr,
                       input logic e_rxf, input logic e_txe, input logic e_rxr, input logic e_txv,
                       input logic [6:0] e_txd, input logic [6:0] e_bus);
        vec_t v;
        v.rd = rd; v.wr = wr; v.drv = drv; v.dval = dval; v.rxd = rxd; v.rxv = rxv; v.txr = txr;
        v.e_rxf = e_rxf; v.e_txe = e_txe; v.e_rxr = e_rxr; v.e_txv = e_txv;
        v.e_txd = e_txd; v.e_bus = e_bus;
        vecs.push_back(v);
    endtask

    task automatic bus_write(input logic [6:0] val);
        fifo_wr = 1'b0; tb_drv = 1'b1; tb_val = val;
        tick();
        tick();
        fifo_wr = 1'b1; tb_drv = 1'b0;
        tick();
    endtask

    initial begin
        //   rd wr drv dval   rxd    rxv txr | rxf txe rxr txv txd    bus
        add(1, 1, 0, 7'h00, 7'h41, 1, 0,   1, 0, 1, 0, 7'h00, BUS_Z);
        add(1, 1, 0, 7'h00, 7'h42, 1, 0,   0, 0, 1, 0, 7'h00, BUS_Z);
        add(0, 1, 0, 7'h00, 7'h00, 0, 0,   1, 0, 1, 0, 7'h00, 7'h41);
        add(0, 1, 0, 7'h00, 7'h00, 0, 0,   1, 0, 1, 0, 7'h00, 7'h41);
        add(1, 1, 0, 7'h00, 7'h00, 0, 0,   1, 0, 1, 0, 7'h00, BUS_Z);
        add(1, 1, 0, 7'h00, 7'h00, 0, 0,   0, 0, 1, 0, 7'h00, BUS_Z);
        add(0, 1, 0, 7'h00, 7'h00, 0, 0,   1, 0, 1, 0, 7'h00, 7'h42);
        add(0, 1, 0, 7'h00, 7'h00, 0, 0,   1, 0, 1, 0, 7'h00, 7'h42);
        add(1, 1, 0, 7'h00, 7'h00, 0, 0,   1, 0, 1, 0, 7'h00, BUS_Z);
        add(1, 1, 0, 7'h00, 7'h00, 0, 0,   1, 0, 1, 0, 7'h00, BUS_Z);
        add(1, 0, 1, 7'h55, 7'h00, 0, 0,   1, 1, 1, 0, 7'h00, 7'h55);
        add(1, 0, 1, 7'h55, 7'h00, 0, 0,   1, 1, 1, 0, 7'h00, 7'h55);
        add(1, 1, 0, 7'h00, 7'h00, 0, 0,   1, 0, 1, 1, 7'h55, BUS_Z);
        add(1, 1, 0, 7'h00, 7'h00, 0, 1,   1, 0, 1, 0, 7'h00, BUS_Z);
        add(1, 1, 0, 7'h00, 7'h00, 0, 0,   1, 0, 1, 0, 7'h00, BUS_Z);

        // reset state
        tick();
        tick();
        chk("rst_rxf", fifo_rxf, 1);
        chk("rst_txe", fifo_txe, 1);
        chk("rst_bus", fifo_data, BUS_Z);
        chk("rst_txv", tx_valid, 0);
        chk("rst_err", {err_rd_empty, err_wr_full}, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_txe", fifo_txe, 0);
        chk("post_rst_rxf", fifo_rxf, 1);
        chk("post_rst_rxr", rx_ready, 1);
        chk("post_rst_txv", tx_valid, 0);

        foreach (vecs[i]) begin
            fifo_rd = vecs[i].rd; fifo_wr = vecs[i].wr; tb_drv = vecs[i].drv; tb_val = vecs[i].dval;
            rx_data = vecs[i].rxd; rx_valid = vecs[i].rxv; tx_ready = vecs[i].txr;
            tick();
            chk($sformatf("v%0d_rxf", i), fifo_rxf, vecs[i].e_rxf);
            chk($sformatf("v%0d_txe", i), fifo_txe, vecs[i].e_txe);
            chk($sformatf("v%0d_rxr", i), rx_ready, vecs[i].e_rxr);
            chk($sformatf("v%0d_txv", i), tx_valid, vecs[i].e_txv);
            if (vecs[i].e_txv) chk($sformatf("v%0d_txd", i), tx_data, vecs[i].e_txd);
            chk($sformatf("v%0d_bus", i), fifo_data, vecs[i].e_bus);
            chk($sformatf("v%0d_err", i), {err_rd_empty, err_wr_full}, 0);
        end
        tx_ready = 1'b0; rx_valid = 1'b0;

        // TX fill, then one write too many
        for (int i = 0; i < DEPTH; i++) bus_write(7'h10 + 7'(i));
        tick();
        chk("txfull_txe", fifo_txe, 1);
        chk("txfull_txd", tx_data, 7'h10);
        chk("txfull_err0", err_wr_full, 0);
        bus_write(7'h77);
        chk("txovf_err", err_wr_full, 1);
        chk("txovf_txd", tx_data, 7'h10);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("txdrain%0d", i), {tx_valid, tx_data}, {1'b1, 7'h10 + 7'(i)});
            tx_ready = 1'b1;
            tick();
        end
        tx_ready = 1'b0;
        chk("txdrain_empty", tx_valid, 0);

        // read strobe with RX empty
        fifo_rd = 1'b0;
        tick();
        chk("rdempty_bus", fifo_data, BUS_Z);
        chk("rdempty_err", err_rd_empty, 1);
        fifo_rd = 1'b1;
        tick();
        tick();
        chk("rdempty_rxf", fifo_rxf, 1);

        // RX full with simultaneous host push and bus pop, across pointer wrap
        rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 7'h20 + 7'(i);
            tick();
        end
        rx_valid = 1'b0;
        #1 chk("rxfull_rdy", rx_ready, 0);
        fifo_rd = 1'b0;
        tick();
        chk("rxfull_bus", fifo_data, 7'h20);
        tick();
        fifo_rd = 1'b1; rx_valid = 1'b1; rx_data = 7'h28;
        #1 chk("rxswap_rdy", rx_ready, 1);
        tick();
        rx_valid = 1'b0;
        #1 chk("rxswap_full", rx_ready, 0);
        for (int i = 1; i <= DEPTH; i++) begin
            fifo_rd = 1'b0;
            tick();
            chk($sformatf("rxdrain%0d", i), fifo_data, 7'h20 + 7'(i));
            fifo_rd = 1'b1;
            tick();
        end
        tick();
        chk("rxdrain_rxf", fifo_rxf, 1);
        chk("rxdrain_bus", fifo_data, BUS_Z);

        // reset asserted mid-read
        rx_valid = 1'b1; rx_data = 7'h33;
        tick();
        rx_valid = 1'b0; fifo_rd = 1'b0;
        tick();
        chk("midrd_bus", fifo_data, 7'h33);
        #2 reset = 1'b0;
        #1;
        chk("midrd_rst_bus", fifo_data, BUS_Z);
        chk("midrd_rst_rxf", fifo_rxf, 1);
        chk("midrd_rst_err", {err_rd_empty, err_wr_full}, 0);
        fifo_rd = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("midrd_rel_rxf", fifo_rxf, 1);
        chk("midrd_rel_txe", fifo_txe, 0);
        chk("midrd_rel_rxr", rx_ready, 1);
        chk("midrd_rel_bus", fifo_data, BUS_Z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
